mesh_task_sched: RTL and testbench

Run-level controller for the 2x4 mesh traffic test. It sequences one traffic run: flush the selected PEs, enable them, wait for every selected PE to raise both its send-finish and receive-finish flag, and report the result. It sits beside the mesh, drives the mesh pe_enable / pe_flush_wire inputs, and watches the mesh finish-flag outputs. A cycle budget bounds each run, and abort stops it early.

---
 rtl/mesh_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 29 ++
 rtl/mesh_task_sched.sv | 135 +++++++++++++
 tb/tb_mesh_task_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_ctrl_pkg.sv
// Shared definitions for the mesh traffic-test controllers: run FSM encoding and mesh size.
package mesh_ctrl_pkg;

    localparam int PE_NUM = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a "next count reaches limit" flag.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] lim,
    output logic [CNT_W-1:0] count,
    output logic             lim_hit
);

    // One extra bit keeps count+1 from wrapping when count is already saturated.
    assign lim_hit = (lim != '0) &&
                     (({1'b0, count} + (CNT_W+1)'(1)) >= {1'b0, lim});

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mesh_task_sched.sv
// Run-level sequencer for the 2x4 mesh traffic test: flush, enable, wait for finish flags, report.
module mesh_task_sched #(
    parameter int PE_NUM    = mesh_ctrl_pkg::PE_NUM,
    parameter int CNT_W     = 16,
    parameter int FLUSH_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PE_NUM-1:0] pe_mask,
    input  logic [CNT_W-1:0]  timeout_lim,
    input  logic [PE_NUM-1:0] send_finish,
    input  logic [PE_NUM-1:0] recv_finish,
    output logic [PE_NUM-1:0] pe_enable,
    output logic [PE_NUM-1:0] pe_flush,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic              aborted,
    output logic [PE_NUM-1:0] fail_mask,
    output logic [CNT_W-1:0]  run_cycles
);

    import mesh_ctrl_pkg::*;

    localparam int FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    sched_state_e        state_q, state_d;
    logic [PE_NUM-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]    lim_q, lim_d;
    logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                timed_out_d, aborted_d;
    logic [PE_NUM-1:0]   fail_mask_d, fin;
    logic                accept, run_inc, lim_hit;

    assign fin = send_finish & recv_finish & mask_q;

    sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .inc     (run_inc),
        .lim     (lim_q),
        .count   (run_cycles),
        .lim_hit (lim_hit)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        lim_d       = lim_q;
        flush_cnt_d = flush_cnt_q;
        timed_out_d = timed_out;
        aborted_d   = aborted;
        fail_mask_d = fail_mask;
        accept      = 1'b0;
        run_inc     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && (pe_mask != '0)) begin
                    accept      = 1'b1;
                    mask_d      = pe_mask;
                    lim_d       = timeout_lim;
                    timed_out_d = 1'b0;
                    aborted_d   = 1'b0;
                    fail_mask_d = '0;
                    flush_cnt_d = '0;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                if (abort) begin
                    aborted_d   = 1'b1;
                    fail_mask_d = mask_q;
                    state_d     = DONE;
                end else if (flush_cnt_q == FLUSH_W'(FLUSH_CYC - 1)) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            RUN: begin
                run_inc = 1'b1;
                // Finish outranks abort, which outranks the cycle budget.
                if (fin == mask_q) begin
                    state_d = DONE;
                end else if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (lim_hit) begin
                    timed_out_d = 1'b1;
                    state_d     = DONE;
                end
                if (state_d == DONE) begin
                    fail_mask_d = mask_q & ~fin;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state, so nothing is combinational to a pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            lim_q       <= '0;
            flush_cnt_q <= '0;
            pe_enable   <= '0;
            pe_flush    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            aborted     <= 1'b0;
            fail_mask   <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            lim_q       <= lim_d;
            flush_cnt_q <= flush_cnt_d;
            pe_enable   <= (state_d == RUN)   ? mask_d : '0;
            pe_flush    <= (state_d == FLUSH) ? mask_d : '0;
            busy        <= (state_d != IDLE);
            done        <= (state_d == DONE);
            timed_out   <= timed_out_d;
            aborted     <= aborted_d;
            fail_mask   <= fail_mask_d;
        end
    end

endmodule

// File: tb/tb_mesh_task_sched.sv
// Randomized scoreboard bench for mesh_task_sched against a per-run behavioural result model.
module tb_mesh_task_sched;

    localparam int NEVER = 999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  pe_mask = '0;
    logic [15:0] timeout_lim = '0;
    logic [7:0]  send_finish = '0;
    logic [7:0]  recv_finish = '0;
    logic [7:0]  pe_enable, pe_flush, fail_mask;
    logic        busy, done, timed_out, aborted;
    logic [15:0] run_cycles;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] fail;
        logic       to;
        logic       ab;
        int         cyc;
    } res_t;

    res_t exp_q[$];

    mesh_task_sched #(.PE_NUM(8), .CNT_W(16), .FLUSH_CYC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .pe_mask     (pe_mask),
        .timeout_lim (timeout_lim),
        .send_finish (send_finish),
        .recv_finish (recv_finish),
        .pe_enable   (pe_enable),
        .pe_flush    (pe_flush),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .aborted     (aborted),
        .fail_mask   (fail_mask),
        .run_cycles  (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Walks RUN cycles 1,2,... applying the exit rules in priority order.
    function automatic res_t model(input logic [7:0] mask, input logic [15:0] lim,
                                   input int s_at[8], input int r_at[8],
                                   input int ab_run, input int ab_flush);
        res_t r;
        logic [7:0] fin;
        r.to = 1'b0; r.ab = 1'b0; r.fail = '0; r.cyc = -1;
        if (ab_flush != 0) begin
            r.ab = 1'b1; r.fail = mask; r.cyc = 0;
            return r;
        end
        for (int k = 1; k <= 2000; k++) begin
            fin = '0;
            for (int i = 0; i < 8; i++)
                if (mask[i] && s_at[i] <= k && r_at[i] <= k) fin[i] = 1'b1;
            if (fin == mask) begin
                r.cyc = k; return r;
            end
            if (k == ab_run) begin
                r.ab = 1'b1; r.fail = mask & ~fin; r.cyc = k; return r;
            end
            if (lim != 0 && k >= int'(lim)) begin
                r.to = 1'b1; r.fail = mask & ~fin; r.cyc = k; return r;
            end
        end
        return r;
    endfunction

    // Monitor: every done pulse retires one expected run result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending run at %0t", $time);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("res_fail_mask", 64'(fail_mask), 64'(e.fail));
                check("res_timed_out", 64'(timed_out), 64'(e.to));
                check("res_aborted", 64'(aborted), 64'(e.ab));
                check("res_run_cycles", 64'(run_cycles), 64'(e.cyc));
            end
        end
    end

    // Drives one run; j counts posedges after the accepted start (FLUSH_CYC = 4).
    task automatic run_case(input logic [7:0] mask, input logic [15:0] lim,
                            input int s_at[8], input int r_at[8],
                            input int ab_run, input int ab_flush, input int start_k);
        res_t r;
        int   last_j, ph, k;
        r = model(mask, lim, s_at, r_at, ab_run, ab_flush);
        exp_q.push_back(r);
        @(negedge clk);
        start = 1'b1; pe_mask = mask; timeout_lim = lim; abort = 1'b0;
        send_finish = 8'($urandom); recv_finish = 8'($urandom);
        @(negedge clk);
        start = 1'b0; pe_mask = 8'($urandom); timeout_lim = 16'($urandom);
        last_j = (ab_flush != 0) ? ab_flush + 1 : r.cyc + 5;
        for (int j = 0; j <= last_j; j++) begin
            // ph: 0 FLUSH, 1 RUN, 2 DONE, 3 IDLE
            if (ab_flush != 0) ph = (j < ab_flush) ? 0 : (j == ab_flush) ? 2 : 3;
            else ph = (j <= 3) ? 0 : (j <= r.cyc + 3) ? 1 : (j == r.cyc + 4) ? 2 : 3;
            check("pe_flush", 64'(pe_flush), (ph == 0) ? 64'(mask) : 64'(0));
            check("pe_enable", 64'(pe_enable), (ph == 1) ? 64'(mask) : 64'(0));
            check("busy", 64'(busy), 64'(ph != 3));
            check("done", 64'(done), 64'(ph == 2));
            if (ph <= 1) begin
                check("status_cleared", 64'({timed_out, aborted, fail_mask}), 64'(0));
                check("run_cycles_live", 64'(run_cycles), (ph == 1) ? 64'(j - 4) : 64'(0));
            end else if (ph == 3) begin
                check("status_sticky", 64'({timed_out, aborted, fail_mask, run_cycles}),
                      64'({r.to, r.ab, r.fail, 16'(r.cyc)}));
            end
            start = 1'b0;
            abort = 1'b0;
            if (ph == 1) begin
                k = j - 3;
                for (int i = 0; i < 8; i++) begin
                    send_finish[i] = (k >= s_at[i]);
                    recv_finish[i] = (k >= r_at[i]);
                end
                abort = (k == ab_run);
                if (k == start_k) begin
                    start = 1'b1;
                    pe_mask = 8'($urandom_range(1, 255));
                end
            end else begin
                send_finish = 8'($urandom);
                recv_finish = 8'($urandom);
                if (ph == 0) abort = (ab_flush != 0) && (j + 1 == ab_flush);
                else abort = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0; send_finish = '0; recv_finish = '0;
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        start = 1'b1; pe_mask = 8'hFF; timeout_lim = '0; send_finish = '0; recv_finish = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_reset_enable", 64'(pe_enable), 64'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pe", 64'({pe_enable, pe_flush, busy, done}), 64'(0));
        check("async_reset_status", 64'({timed_out, aborted, fail_mask, run_cycles}), 64'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s[8], r[8];
        logic [7:0]  m;
        logic [15:0] l;
        int ab_run, ab_flush;
        bit stuck;

        repeat (2) @(negedge clk);
        check("reset_pe", 64'({pe_enable, pe_flush, busy, done}), 64'(0));
        check("reset_status", 64'({timed_out, aborted, fail_mask, run_cycles}), 64'(0));
        #2 rst_n = 1'b1;

        // Clean run: flags rise 20 cycles after RUN entry.
        s = '{default: 21}; r = '{default: 21};
        run_case(8'hFF, 16'd0, s, r, 0, 0, 0);
        // Budget exhaustion with PE2 never receiving.
        s = '{default: 10}; r = '{default: 10}; r[2] = NEVER;
        run_case(8'h0F, 16'd50, s, r, 0, 0, 0);
        // Finish and budget in the same cycle.
        s = '{default: NEVER}; r = '{default: NEVER}; s[0] = 10; r[0] = 10;
        run_case(8'h01, 16'd10, s, r, 0, 0, 0);
        // Abort in second FLUSH cycle, then in RUN cycle 5 with a start pulsed during RUN.
        s = '{default: NEVER}; r = '{default: NEVER};
        run_case(8'h3C, 16'd0, s, r, 0, 2, 0);
        run_case(8'hAA, 16'd0, s, r, 5, 0, 3);
        // Flags already high at RUN entry.
        s = '{default: 1}; r = '{default: 1};
        run_case(8'h81, 16'd7, s, r, 0, 0, 0);

        // Ignored start with an empty mask while flags toggle in IDLE.
        @(negedge clk);
        start = 1'b1; pe_mask = 8'h00;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_finish = 8'($urandom); recv_finish = 8'($urandom);
            check("ignored_busy", 64'({busy, pe_flush, pe_enable}), 64'(0));
            @(negedge clk);
        end
        send_finish = '0; recv_finish = '0;

        reset_mid_run();
        s = '{default: 3}; r = '{default: 6};
        run_case(8'h5A, 16'd0, s, r, 0, 0, 0);

        for (int n = 0; n < 20; n++) begin
            m = 8'($urandom_range(1, 255));
            l = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            stuck = 1'b0;
            for (int i = 0; i < 8; i++) begin
                s[i] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(1, 30));
                r[i] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(1, 30));
                if (m[i] && (s[i] == NEVER || r[i] == NEVER)) stuck = 1'b1;
            end
            ab_run   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
            ab_flush = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
            if (l == 0 && ab_run == 0 && stuck) l = 16'd45;
            run_case(m, l, s, r, ab_run, ab_flush, int'($urandom_range(1, 10)));
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL missing_done: got %0d runs without done expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
